// File: rtl/pc_unit_ras_pkg.sv
// rtl/pc_unit_ras_pkg.sv - shared fetch-stage PC constants and next-PC select encoding
package pc_unit_ras_pkg;

  localparam int          PC_WIDTH        = 16;
  localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;
  localparam int          PC_INC          = 1;

  typedef enum logic [2:0] {
    SEL_SEQ      = 3'd0,
    SEL_REDIRECT = 3'd1,
    SEL_HOLD     = 3'd2,
    SEL_CALL     = 3'd3,
    SEL_RETURN   = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_ras_ras_stack.sv
// rtl/pc_unit_ras_ras_stack.sv - circular return-address LIFO, oldest entry overwritten when full
module ras_stack #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic [CW-1:0]    count;

  assign ptr_inc  = top_ptr + PW'(1);
  assign ptr_dec  = top_ptr - PW'(1);
  assign top_data = mem[top_ptr];
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);

  // Push takes precedence; the count saturates so an overwrite leaves it at depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= ptr_inc;
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      top_ptr <= ptr_dec;
      count   <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - IF-stage PC register with stall, redirect and call/return via RAS
module pc_unit_ras
  import pc_unit_ras_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0] INC          = WIDTH'(PC_INC),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall,
  input  logic             Redirect_Valid,
  input  logic [WIDTH-1:0] Redirect_Target,
  input  logic             Call,
  input  logic [WIDTH-1:0] Call_Target,
  input  logic             Return,
  output logic [WIDTH-1:0] PC_Out,
  output logic [WIDTH-1:0] PC_Plus,
  output logic             Ras_Empty,
  output logic             Ras_Full,
  output logic             Ras_Underflow
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;
  logic             underflow_set;

  assign PC_Plus = PC_Out + INC;

  // Priority: redirect > stall > call > return > sequential.
  always_comb begin
    sel           = SEL_SEQ;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    underflow_set = 1'b0;
    if (Redirect_Valid) begin
      sel = SEL_REDIRECT;
    end else if (Stall) begin
      sel = SEL_HOLD;
    end else if (Call) begin
      sel      = SEL_CALL;
      ras_push = 1'b1;
    end else if (Return) begin
      if (Ras_Empty) begin
        underflow_set = 1'b1;
      end else begin
        sel     = SEL_RETURN;
        ras_pop = 1'b1;
      end
    end
  end

  always_comb begin
    pc_next = PC_Plus;
    case (sel)
      SEL_REDIRECT: pc_next = Redirect_Target;
      SEL_HOLD:     pc_next = PC_Out;
      SEL_CALL:     pc_next = Call_Target;
      SEL_RETURN:   pc_next = ras_top;
      default:      pc_next = PC_Plus;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PC_Out        <= RESET_VECTOR;
      Ras_Underflow <= 1'b0;
    end else begin
      PC_Out <= pc_next;
      if (underflow_set) Ras_Underflow <= 1'b1;
    end
  end

  ras_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (CLK),
    .rst_n    (RST),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(PC_Plus),
    .top_data (ras_top),
    .empty    (Ras_Empty),
    .full     (Ras_Full)
  );

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - scoreboard bench for pc_unit_ras
module tb_pc_unit_ras;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall;
  logic        Redirect_Valid;
  logic [15:0] Redirect_Target;
  logic        Call;
  logic [15:0] Call_Target;
  logic        Return;
  logic [15:0] PC_Out;
  logic [15:0] PC_Plus;
  logic        Ras_Empty;
  logic        Ras_Full;
  logic        Ras_Underflow;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  always #5 CLK = ~CLK;

  pc_unit_ras #(
    .WIDTH       (16),
    .RESET_VECTOR(16'h0010),
    .INC         (16'h0001),
    .RAS_DEPTH   (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Stall          (Stall),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_Target(Redirect_Target),
    .Call           (Call),
    .Call_Target    (Call_Target),
    .Return         (Return),
    .PC_Out         (PC_Out),
    .PC_Plus        (PC_Plus),
    .Ras_Empty      (Ras_Empty),
    .Ras_Full       (Ras_Full),
    .Ras_Underflow  (Ras_Underflow)
  );

  // Drive one cycle of control, sample 1ns after the edge, then return to idle.
  task automatic step(input logic st, input logic rv, input logic [15:0] rt,
                      input logic c, input logic [15:0] ct, input logic r);
    Stall = st; Redirect_Valid = rv; Redirect_Target = rt;
    Call = c; Call_Target = ct; Return = r;
    @(posedge CLK);
    #1;
    Stall = 0; Redirect_Valid = 0; Call = 0; Return = 0;
  endtask

  task automatic test_reset;
    RST = 0; Stall = 0; Redirect_Valid = 0; Redirect_Target = '0;
    Call = 0; Call_Target = '0; Return = 0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (PC_Out !== 16'h0010) begin bad++; $display("FAIL reset_pc actual=%h required=0010", PC_Out); end
    total++; if ({Ras_Empty, Ras_Full, Ras_Underflow} !== 3'b100) begin bad++; $display("FAIL reset_flags actual=%b required=100", {Ras_Empty, Ras_Full, Ras_Underflow}); end
    RST = 1;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(16'h0010 + 16'(i));
      step(0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      total++; if (PC_Out !== e) begin bad++; $display("FAIL seq_%0d actual=%h required=%h", i, PC_Out, e); end
    end
    #2 RST = 0;
    #1;
    total++; if (PC_Out !== 16'h0010) begin bad++; $display("FAIL async_reset actual=%h required=0010", PC_Out); end
    RST = 1;
    exp_q.push_back(16'h0011);
    step(0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL post_reset actual=%h required=%h", PC_Out, e); end
  endtask

  task automatic test_stall;
    exp_q.push_back(16'h0020); step(0, 1, 16'h0020, 0, 0, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL stall_setup actual=%h required=%h", PC_Out, e); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'h0020);
      step(1, 0, 0, 0, 0, 1);
      e = exp_q.pop_front();
      total++; if (PC_Out !== e) begin bad++; $display("FAIL stall_hold_%0d actual=%h required=%h", i, PC_Out, e); end
    end
    total++; if (Ras_Underflow !== 1'b0) begin bad++; $display("FAIL stall_ignores_return actual=%b required=0", Ras_Underflow); end
    exp_q.push_back(16'h0100); step(1, 1, 16'h0100, 0, 0, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL stall_redirect actual=%h required=%h", PC_Out, e); end
  endtask

  task automatic test_call_return;
    step(0, 1, 16'h0030, 0, 0, 0);
    exp_q.push_back(16'h0200); step(0, 0, 0, 1, 16'h0200, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL call_pc actual=%h required=%h", PC_Out, e); end
    total++; if (Ras_Empty !== 1'b0) begin bad++; $display("FAIL call_empty actual=%b required=0", Ras_Empty); end
    exp_q.push_back(16'h0201); exp_q.push_back(16'h0202); exp_q.push_back(16'h0031);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, i == 2);
      e = exp_q.pop_front();
      total++; if (PC_Out !== e) begin bad++; $display("FAIL callret_%0d actual=%h required=%h", i, PC_Out, e); end
    end
    total++; if (Ras_Empty !== 1'b1) begin bad++; $display("FAIL ret_empty actual=%b required=1", Ras_Empty); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 16'(i * 16), 0, 0, 0);
      exp_q.push_back(16'h0400); step(0, 0, 0, 1, 16'h0400, 0);
      e = exp_q.pop_front();
      total++; if (PC_Out !== e) begin bad++; $display("FAIL ovf_call_%0d actual=%h required=%h", i, PC_Out, e); end
    end
    total++; if (Ras_Full !== 1'b1) begin bad++; $display("FAIL ovf_full actual=%b required=1", Ras_Full); end
    exp_q.push_back(16'h0051); exp_q.push_back(16'h0041);
    exp_q.push_back(16'h0031); exp_q.push_back(16'h0021);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      e = exp_q.pop_front();
      total++; if (PC_Out !== e) begin bad++; $display("FAIL ovf_ret_%0d actual=%h required=%h", i, PC_Out, e); end
    end
    total++; if ({Ras_Empty, Ras_Full, Ras_Underflow} !== 3'b100) begin bad++; $display("FAIL ovf_drained actual=%b required=100", {Ras_Empty, Ras_Full, Ras_Underflow}); end
    exp_q.push_back(16'h0022); exp_q.push_back(16'h0023);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, i == 0);
      e = exp_q.pop_front();
      total++; if (PC_Out !== e) begin bad++; $display("FAIL udf_pc_%0d actual=%h required=%h", i, PC_Out, e); end
      total++; if (Ras_Underflow !== 1'b1) begin bad++; $display("FAIL udf_sticky_%0d actual=%b required=1", i, Ras_Underflow); end
    end
  endtask

  task automatic test_conflicts;
    #2 RST = 0;
    #1;
    total++; if (Ras_Underflow !== 1'b0) begin bad++; $display("FAIL udf_cleared actual=%b required=0", Ras_Underflow); end
    RST = 1;
    step(0, 1, 16'h0040, 0, 0, 0);
    exp_q.push_back(16'h0300); exp_q.push_back(16'h0041); exp_q.push_back(16'h0500);
    step(0, 0, 0, 1, 16'h0300, 1);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL call_ret_pc actual=%h required=%h", PC_Out, e); end
    total++; if (Ras_Empty !== 1'b0) begin bad++; $display("FAIL call_ret_count actual=%b required=0", Ras_Empty); end
    step(0, 0, 0, 0, 0, 1);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL call_ret_pop actual=%h required=%h", PC_Out, e); end
    step(0, 1, 16'h0500, 1, 16'h0600, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL redir_call_pc actual=%h required=%h", PC_Out, e); end
    total++; if (Ras_Empty !== 1'b1) begin bad++; $display("FAIL redir_call_count actual=%b required=1", Ras_Empty); end
  endtask

  task automatic test_wrap;
    step(0, 1, 16'hFFFF, 0, 0, 0);
    total++; if (PC_Plus !== 16'h0000) begin bad++; $display("FAIL wrap_plus actual=%h required=0000", PC_Plus); end
    exp_q.push_back(16'h0000); exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0700); exp_q.push_back(16'h0000);
    step(0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL wrap_seq actual=%h required=%h", PC_Out, e); end
    step(0, 1, 16'hFFFF, 0, 0, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL wrap_set actual=%h required=%h", PC_Out, e); end
    step(0, 0, 0, 1, 16'h0700, 0);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL wrap_call actual=%h required=%h", PC_Out, e); end
    step(0, 0, 0, 0, 0, 1);
    e = exp_q.pop_front();
    total++; if (PC_Out !== e) begin bad++; $display("FAIL wrap_ret actual=%h required=%h", PC_Out, e); end
  endtask

  initial begin
    test_reset;
    test_stall;
    test_call_return;
    test_overflow;
    test_conflicts;
    test_wrap;
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left actual=%0d required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
